cache_data_bank: RTL and testbench

CACHE_DATA_BANK -- requirements
Module: cache_data_bank

---
 rtl/cache_data_bank_pkg.sv | 29 ++
 rtl/cache_data_array.sv | 72 +++++++
 rtl/cache_data_bank.sv | 150 +++++++++++++++
 tb/tb_cache_data_bank.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_data_bank_pkg.sv
// Shared definitions for the cache data bank: default geometry, eviction state
// encoding and the byte-lane merge used by strobed stores.
package cache_data_bank_pkg;

   localparam int DEF_SETS  = 256;
   localparam int DEF_WAYS  = 2;
   localparam int DEF_WORDS = 4;

   typedef enum logic {
      EV_IDLE = 1'b0,
      EV_SEND = 1'b1
   } ev_state_e;

   function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  strb);
      logic [31:0] res;
      res = old_word;
      for (int b = 0; b < 4; b++) begin
         if (strb[b]) begin
            res[b*8 +: 8] = new_word[b*8 +: 8];
         end else begin
            res[b*8 +: 8] = old_word[b*8 +: 8];
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/cache_data_array.sv
// Byte-maskable line storage: one word read port, one full-line read port,
// a strobed word write port and a whole-line fill port. Contents are never reset.
module cache_data_array
   import cache_data_bank_pkg::*;
#(
   parameter int SETS  = DEF_SETS,
   parameter int WAYS  = DEF_WAYS,
   parameter int WORDS = DEF_WORDS
) (
   input  logic                          clk,
   input  logic [$clog2(SETS)-1:0]       rd_index,
   input  logic [$clog2(WAYS)-1:0]       rd_way,
   input  logic [$clog2(WORDS)-1:0]      rd_offset,
   output logic [31:0]                   rd_word,
   input  logic [$clog2(SETS)-1:0]       ln_index,
   input  logic [$clog2(WAYS)-1:0]       ln_way,
   output logic [WORDS-1:0][31:0]        ln_data,
   input  logic                          wr_en,
   input  logic [3:0]                    wr_strb,
   input  logic [$clog2(SETS)-1:0]       wr_index,
   input  logic [$clog2(WAYS)-1:0]       wr_way,
   input  logic [$clog2(WORDS)-1:0]      wr_offset,
   input  logic [31:0]                   wr_data,
   input  logic                          fill_en,
   input  logic [$clog2(SETS)-1:0]       fill_index,
   input  logic [$clog2(WAYS)-1:0]       fill_way,
   input  logic [WORDS*32-1:0]           fill_line
);

   localparam int AW = $clog2(SETS) + $clog2(WAYS);

   logic [WORDS-1:0][31:0] mem_r [SETS*WAYS];
   logic [AW-1:0]          rd_addr_s;
   logic [AW-1:0]          ln_addr_s;
   logic [AW-1:0]          wr_addr_s;
   logic [AW-1:0]          fill_addr_s;
   logic [WORDS-1:0][31:0] fill_words_s;
   logic [31:0]            wr_base_s;
   logic [31:0]            wr_word_s;

   assign rd_addr_s    = {rd_index, rd_way};
   assign ln_addr_s    = {ln_index, ln_way};
   assign wr_addr_s    = {wr_index, wr_way};
   assign fill_addr_s  = {fill_index, fill_way};
   assign fill_words_s = fill_line;

   assign rd_word = mem_r[rd_addr_s][rd_offset];
   assign ln_data = mem_r[ln_addr_s];

   // Store merge base: a same-cycle fill of the store's line supplies the unstrobed bytes
   always_comb begin
      wr_base_s = 32'h0000_0000;
      if (fill_en && (fill_addr_s == wr_addr_s)) begin
         wr_base_s = fill_words_s[wr_offset];
      end else begin
         wr_base_s = mem_r[wr_addr_s][wr_offset];
      end
   end

   assign wr_word_s = byte_merge(wr_base_s, wr_data, wr_strb);

   // Storage update; the store is issued after the fill so its bytes win on overlap
   always_ff @(posedge clk) begin
      if (fill_en) begin
         mem_r[fill_addr_s] <= fill_words_s;
      end
      if (wr_en) begin
         mem_r[wr_addr_s][wr_offset] <= wr_word_s;
      end
   end

endmodule

// File: rtl/cache_data_bank.sv
// Cache data bank: registered word reads over cache_data_array plus a victim
// eviction engine that snapshots a line and streams it out word by word.
module cache_data_bank
   import cache_data_bank_pkg::*;
#(
   parameter int SETS  = DEF_SETS,
   parameter int WAYS  = DEF_WAYS,
   parameter int WORDS = DEF_WORDS
) (
   input  logic                          clk,
   input  logic                          resetn,
   input  logic                          rd_en,
   input  logic [$clog2(SETS)-1:0]       rd_index,
   input  logic [$clog2(WAYS)-1:0]       rd_way,
   input  logic [$clog2(WORDS)-1:0]      rd_offset,
   output logic                          rd_valid,
   output logic [31:0]                   rd_data,
   input  logic                          wr_en,
   input  logic [3:0]                    wr_strb,
   input  logic [$clog2(SETS)-1:0]       wr_index,
   input  logic [$clog2(WAYS)-1:0]       wr_way,
   input  logic [$clog2(WORDS)-1:0]      wr_offset,
   input  logic [31:0]                   wr_data,
   input  logic                          fill_en,
   input  logic [$clog2(SETS)-1:0]       fill_index,
   input  logic [$clog2(WAYS)-1:0]       fill_way,
   input  logic [WORDS*32-1:0]           fill_line,
   input  logic                          ev_start,
   input  logic [$clog2(SETS)-1:0]       ev_index,
   input  logic [$clog2(WAYS)-1:0]       ev_way,
   output logic                          ev_busy,
   output logic                          ev_valid,
   input  logic                          ev_ready,
   output logic [31:0]                   ev_data,
   output logic                          ev_last
);

   localparam int              OW     = $clog2(WORDS);
   localparam logic [OW-1:0]   LAST_K = OW'(WORDS - 1);

   logic [31:0]            rd_word_s;
   logic [WORDS-1:0][31:0] line_s;
   logic [WORDS-1:0][31:0] buf_r;
   ev_state_e              state_r;
   logic [OW-1:0]          cnt_r;
   logic [OW-1:0]          cnt_nxt_s;
   logic                   rd_valid_r;
   logic [31:0]            rd_data_r;
   logic                   ev_busy_r;
   logic                   ev_valid_r;
   logic                   ev_last_r;
   logic [31:0]            ev_data_r;

   cache_data_array #(
      .SETS  (SETS),
      .WAYS  (WAYS),
      .WORDS (WORDS)
   ) u_array (
      .clk        (clk),
      .rd_index   (rd_index),
      .rd_way     (rd_way),
      .rd_offset  (rd_offset),
      .rd_word    (rd_word_s),
      .ln_index   (ev_index),
      .ln_way     (ev_way),
      .ln_data    (line_s),
      .wr_en      (wr_en),
      .wr_strb    (wr_strb),
      .wr_index   (wr_index),
      .wr_way     (wr_way),
      .wr_offset  (wr_offset),
      .wr_data    (wr_data),
      .fill_en    (fill_en),
      .fill_index (fill_index),
      .fill_way   (fill_way),
      .fill_line  (fill_line)
   );

   assign cnt_nxt_s = cnt_r + 1'b1;

   assign rd_valid = rd_valid_r;
   assign rd_data  = rd_data_r;
   assign ev_busy  = ev_busy_r;
   assign ev_valid = ev_valid_r;
   assign ev_last  = ev_last_r;
   assign ev_data  = ev_data_r;

   // Read pipeline: array read is sampled before the same edge's write, giving read-first
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rd_valid_r <= 1'b0;
         rd_data_r  <= 32'h0000_0000;
      end else begin
         rd_valid_r <= rd_en;
         if (rd_en) begin
            rd_data_r <= rd_word_s;
         end
      end
   end

   // Eviction engine: snapshot on start, then one word per ev_valid/ev_ready handshake
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_r    <= EV_IDLE;
         cnt_r      <= {OW{1'b0}};
         buf_r      <= {(WORDS*32){1'b0}};
         ev_busy_r  <= 1'b0;
         ev_valid_r <= 1'b0;
         ev_last_r  <= 1'b0;
         ev_data_r  <= 32'h0000_0000;
      end else begin
         case (state_r)
            EV_IDLE: begin
               if (ev_start) begin
                  buf_r      <= line_s;
                  ev_data_r  <= line_s[0];
                  cnt_r      <= {OW{1'b0}};
                  ev_busy_r  <= 1'b1;
                  ev_valid_r <= 1'b1;
                  ev_last_r  <= 1'b0;
                  state_r    <= EV_SEND;
               end
            end
            EV_SEND: begin
               if (ev_valid_r && ev_ready) begin
                  cnt_r <= cnt_nxt_s;
                  if (cnt_r == LAST_K) begin
                     state_r    <= EV_IDLE;
                     ev_busy_r  <= 1'b0;
                     ev_valid_r <= 1'b0;
                     ev_last_r  <= 1'b0;
                     ev_data_r  <= 32'h0000_0000;
                  end else begin
                     ev_data_r <= buf_r[cnt_nxt_s];
                     ev_last_r <= (cnt_nxt_s == LAST_K);
                  end
               end
            end
            default: begin
               state_r    <= EV_IDLE;
               cnt_r      <= {OW{1'b0}};
               ev_busy_r  <= 1'b0;
               ev_valid_r <= 1'b0;
               ev_last_r  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cache_data_bank.sv
// Self-checking bench for cache_data_bank: a table of fill/store/read vectors
// plus hand-written eviction sequences, with read and eviction scoreboards.
module tb_cache_data_bank;

   localparam int SETS  = 256;
   localparam int WAYS  = 2;
   localparam int WORDS = 4;
   localparam int IW    = $clog2(SETS);
   localparam int WW    = $clog2(WAYS);
   localparam int OW    = $clog2(WORDS);

   logic                clk;
   logic                resetn;
   logic                rd_en;
   logic [IW-1:0]       rd_index;
   logic [WW-1:0]       rd_way;
   logic [OW-1:0]       rd_offset;
   logic                rd_valid;
   logic [31:0]         rd_data;
   logic                wr_en;
   logic [3:0]          wr_strb;
   logic [IW-1:0]       wr_index;
   logic [WW-1:0]       wr_way;
   logic [OW-1:0]       wr_offset;
   logic [31:0]         wr_data;
   logic                fill_en;
   logic [IW-1:0]       fill_index;
   logic [WW-1:0]       fill_way;
   logic [WORDS*32-1:0] fill_line;
   logic                ev_start;
   logic [IW-1:0]       ev_index;
   logic [WW-1:0]       ev_way;
   logic                ev_busy;
   logic                ev_valid;
   logic                ev_ready;
   logic [31:0]         ev_data;
   logic                ev_last;

   int tests;
   int fails;
   logic [31:0] rd_q[$];
   logic [32:0] ev_q[$];

   typedef struct {
      logic [IW-1:0] idx;
      logic [WW-1:0] way;
      logic [OW-1:0] off;
      logic [31:0]   pre;
      logic [3:0]    strb;
      logic [31:0]   data;
      logic [31:0]   exp;
   } vec_t;

   vec_t vecs[6];

   cache_data_bank #(.SETS(SETS), .WAYS(WAYS), .WORDS(WORDS)) dut (
      .clk(clk), .resetn(resetn),
      .rd_en(rd_en), .rd_index(rd_index), .rd_way(rd_way), .rd_offset(rd_offset),
      .rd_valid(rd_valid), .rd_data(rd_data),
      .wr_en(wr_en), .wr_strb(wr_strb), .wr_index(wr_index), .wr_way(wr_way),
      .wr_offset(wr_offset), .wr_data(wr_data),
      .fill_en(fill_en), .fill_index(fill_index), .fill_way(fill_way), .fill_line(fill_line),
      .ev_start(ev_start), .ev_index(ev_index), .ev_way(ev_way), .ev_busy(ev_busy),
      .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_data(ev_data), .ev_last(ev_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Observes outputs on the falling edge and scores reads and eviction beats
   task automatic monitor();
      logic        prev_rd;
      logic        stall;
      logic [31:0] hdata;
      logic        hlast;
      logic [32:0] e;
      prev_rd = 1'b0;
      stall   = 1'b0;
      hdata   = 32'h0;
      hlast   = 1'b0;
      forever begin
         @(negedge clk);
         if (!resetn) begin
            prev_rd = 1'b0;
            stall   = 1'b0;
         end else begin
            if (rd_valid || prev_rd) begin
               check("rd_valid", {31'h0, rd_valid}, {31'h0, prev_rd});
               if (rd_valid) begin
                  if (rd_q.size() == 0) check("rd_unexpected", 32'h1, 32'h0);
                  else check("rd_data", rd_data, rd_q.pop_front());
               end
            end
            prev_rd = rd_en;
            if (stall) begin
               check("ev_hold_valid", {31'h0, ev_valid}, 32'h1);
               check("ev_hold_data", ev_data, hdata);
               check("ev_hold_last", {31'h0, ev_last}, {31'h0, hlast});
            end
            if (ev_valid) check("ev_busy_with_valid", {31'h0, ev_busy}, 32'h1);
            if (ev_valid && ev_ready) begin
               if (ev_q.size() == 0) begin
                  check("ev_unexpected", 32'h1, 32'h0);
               end else begin
                  e = ev_q.pop_front();
                  check("ev_data", ev_data, e[31:0]);
                  check("ev_last", {31'h0, ev_last}, {31'h0, e[32]});
               end
            end
            stall = ev_valid && !ev_ready;
            hdata = ev_data;
            hlast = ev_last;
         end
      end
   endtask

   task automatic push_line(input logic [31:0] w0, input logic [31:0] w1,
                            input logic [31:0] w2, input logic [31:0] w3);
      ev_q.push_back({1'b0, w0});
      ev_q.push_back({1'b0, w1});
      ev_q.push_back({1'b0, w2});
      ev_q.push_back({1'b1, w3});
   endtask

   task automatic wait_ev(input int target, input int budget);
      int n;
      n = 0;
      while (ev_q.size() > target && n < budget) begin
         step();
         n++;
      end
      if (ev_q.size() > target) check("ev_timeout", ev_q.size(), target);
   endtask

   task automatic do_read(input logic [IW-1:0] idx, input logic [WW-1:0] way,
                          input logic [OW-1:0] off, input logic [31:0] exp);
      rd_en = 1'b1; rd_index = idx; rd_way = way; rd_offset = off;
      rd_q.push_back(exp);
      step();
      rd_en = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_rd_valid"}, {31'h0, rd_valid}, 32'h0);
      check({tag, "_rd_data"},  rd_data, 32'h0);
      check({tag, "_ev_busy"},  {31'h0, ev_busy}, 32'h0);
      check({tag, "_ev_valid"}, {31'h0, ev_valid}, 32'h0);
      check({tag, "_ev_last"},  {31'h0, ev_last}, 32'h0);
      check({tag, "_ev_data"},  ev_data, 32'h0);
   endtask

   initial begin
      tests = 0; fails = 0;
      resetn = 1'b0;
      rd_en = 1'b0; rd_index = '0; rd_way = '0; rd_offset = '0;
      wr_en = 1'b0; wr_strb = 4'h0; wr_index = '0; wr_way = '0; wr_offset = '0; wr_data = 32'h0;
      fill_en = 1'b0; fill_index = '0; fill_way = '0; fill_line = '0;
      ev_start = 1'b0; ev_index = '0; ev_way = '0; ev_ready = 1'b0;

      vecs[0] = '{idx: 8'd1,   way: 1'b0, off: 2'd0, pre: 32'h0000_0000, strb: 4'b1111, data: 32'h1234_5678, exp: 32'h1234_5678};
      vecs[1] = '{idx: 8'd2,   way: 1'b1, off: 2'd1, pre: 32'hFFFF_FFFF, strb: 4'b0000, data: 32'h0000_0000, exp: 32'hFFFF_FFFF};
      vecs[2] = '{idx: 8'd3,   way: 1'b0, off: 2'd2, pre: 32'hFFFF_FFFF, strb: 4'b0001, data: 32'h0000_0000, exp: 32'hFFFF_FF00};
      vecs[3] = '{idx: 8'd4,   way: 1'b1, off: 2'd3, pre: 32'h0000_0000, strb: 4'b1000, data: 32'hA5A5_A5A5, exp: 32'hA500_0000};
      vecs[4] = '{idx: 8'd0,   way: 1'b0, off: 2'd1, pre: 32'h1357_2468, strb: 4'b0110, data: 32'hFFFF_FFFF, exp: 32'h13FF_FF68};
      vecs[5] = '{idx: 8'd255, way: 1'b0, off: 2'd3, pre: 32'hCAFE_BABE, strb: 4'b1010, data: 32'h1122_3344, exp: 32'h11FE_33BE};

      fork
         monitor();
         begin
            #500000;
            $display("FAIL watchdog: simulation did not finish");
            $fatal(1, "watchdog");
         end
      join_none

      #12;
      check_all_zero("reset");
      @(posedge clk); #1;
      resetn = 1'b1;
      step();

      for (int i = 0; i < 6; i++) begin
         fill_en = 1'b1; fill_index = vecs[i].idx; fill_way = vecs[i].way;
         fill_line = {WORDS{vecs[i].pre}};
         step();
         fill_en = 1'b0;
         wr_en = 1'b1; wr_index = vecs[i].idx; wr_way = vecs[i].way; wr_offset = vecs[i].off;
         wr_strb = vecs[i].strb; wr_data = vecs[i].data;
         step();
         wr_en = 1'b0;
         do_read(vecs[i].idx, vecs[i].way, vecs[i].off, vecs[i].exp);
         step();
      end

      // Fill set 5 way 1, read word 2 the next cycle
      fill_en = 1'b1; fill_index = 8'd5; fill_way = 1'b1;
      fill_line = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
      step();
      fill_en = 1'b0;
      do_read(8'd5, 1'b1, 2'd2, 32'h3333_3333);
      step();

      // Same-cycle read and strobed store to the same word returns old data
      wr_en = 1'b1; wr_index = 8'd5; wr_way = 1'b1; wr_offset = 2'd2;
      wr_strb = 4'b0101; wr_data = 32'hAABB_CCDD;
      do_read(8'd5, 1'b1, 2'd2, 32'h3333_3333);
      wr_en = 1'b0;
      do_read(8'd5, 1'b1, 2'd2, 32'h33BB_33DD);
      step();

      // Full-rate eviction
      ev_ready = 1'b1; ev_start = 1'b1; ev_index = 8'd5; ev_way = 1'b1;
      push_line(32'h1111_1111, 32'h2222_2222, 32'h33BB_33DD, 32'h4444_4444);
      step();
      ev_start = 1'b0;
      check("ev_busy_after_start", {31'h0, ev_busy}, 32'h1);
      wait_ev(0, 20);
      check("ev_busy_done", {31'h0, ev_busy}, 32'h0);
      check("ev_valid_done", {31'h0, ev_valid}, 32'h0);
      step();

      // Stalling consumer plus stores to the victim line during SEND
      ev_ready = 1'b0; ev_start = 1'b1; ev_index = 8'd5; ev_way = 1'b1;
      push_line(32'h1111_1111, 32'h2222_2222, 32'h33BB_33DD, 32'h4444_4444);
      step();
      ev_start = 1'b0;
      for (int c = 0; c < 40 && ev_q.size() > 0; c++) begin
         ev_ready = c[0];
         wr_en = (c == 1) || (c == 3);
         wr_index = 8'd5; wr_way = 1'b1; wr_strb = 4'b1111; wr_data = 32'hFFFF_FFFF;
         wr_offset = (c == 1) ? 2'd0 : 2'd3;
         step();
      end
      wr_en = 1'b0;
      ev_ready = 1'b1;
      wait_ev(0, 4);
      step();
      check("ev_busy_after_stall", {31'h0, ev_busy}, 32'h0);
      do_read(8'd5, 1'b1, 2'd3, 32'hFFFF_FFFF);
      step();

      // Reset after the second beat abandons the eviction
      ev_ready = 1'b1; ev_start = 1'b1; ev_index = 8'd5; ev_way = 1'b1;
      push_line(32'hFFFF_FFFF, 32'h2222_2222, 32'h33BB_33DD, 32'hFFFF_FFFF);
      step();
      ev_start = 1'b0;
      wait_ev(2, 10);
      #2;
      resetn = 1'b0;
      #1;
      check_all_zero("async_reset");
      ev_q.delete();
      step();
      resetn = 1'b1;
      for (int c = 0; c < 6; c++) step();
      check("ev_valid_post_reset", {31'h0, ev_valid}, 32'h0);
      check("ev_busy_post_reset", {31'h0, ev_busy}, 32'h0);

      // Same-cycle fill and full store: store wins
      fill_en = 1'b1; fill_index = 8'd9; fill_way = 1'b0; fill_line = {WORDS{32'h5A5A_5A5A}};
      wr_en = 1'b1; wr_index = 8'd9; wr_way = 1'b0; wr_offset = 2'd1;
      wr_strb = 4'b1111; wr_data = 32'hDEAD_BEEF;
      step();
      fill_en = 1'b0; wr_en = 1'b0;
      do_read(8'd9, 1'b0, 2'd1, 32'hDEAD_BEEF);
      do_read(8'd9, 1'b0, 2'd0, 32'h5A5A_5A5A);
      step();

      // ev_start while busy is ignored
      ev_ready = 1'b0; ev_start = 1'b1; ev_index = 8'd9; ev_way = 1'b0;
      push_line(32'h5A5A_5A5A, 32'hDEAD_BEEF, 32'h5A5A_5A5A, 32'h5A5A_5A5A);
      step();
      ev_index = 8'd5; ev_way = 1'b1;
      step();
      ev_start = 1'b0; ev_ready = 1'b1;
      wait_ev(0, 20);
      check("ev_busy_end", {31'h0, ev_busy}, 32'h0);
      for (int c = 0; c < 4; c++) step();
      check("ev_valid_end", {31'h0, ev_valid}, 32'h0);
      check("rd_queue_drained", rd_q.size(), 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
